// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the response record and the address legality rule used by reads and preloads.
package imem_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic               err;
        logic [INSTR_W-1:0] instr;
    } rsp_t;

    // A byte address is usable only if word-aligned and inside the word array.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous-reset FIFO with registered storage; the head is read straight from the array.
// Pointers wrap modulo DEPTH; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    // NOTE: storage arrays are not reset; count alone says which entries are live.
    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: preloadable word memory, fixed-latency read pipeline and an
// in-order response queue with valid/ready on both sides and a bounded number of outstanding fetches.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_err,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]   outstanding;
    logic               accept;
    logic               rsp_fire;
    logic               rd_err;
    rsp_t               rd_entry;
    logic               push;
    rsp_t               push_entry;
    rsp_t               head_entry;
    logic               fifo_full;
    logic               fifo_empty;

    assign req_ready = (outstanding < CNT_W'(MAX_OUT)) && !load_en && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign rd_err    = addr_bad(req_addr, DEPTH);

    // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
    always_comb begin
        rd_entry = '{err: rd_err, instr: NOP_INSTR};
        if (!rd_err) rd_entry.instr = mem[req_addr[IDX_W+1:2]];
    end

    always_ff @(posedge clock) begin
        if (load_en && !addr_bad(load_addr, DEPTH)) mem[load_addr[IDX_W+1:2]] <= load_data;
    end

    // The FIFO write is the final delay stage, so only LATENCY-1 pipeline registers sit before it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push       = accept;
            assign push_entry = rd_entry;
        end else begin : g_pipe
            localparam int STAGES = LATENCY - 1;
            logic stage_valid [STAGES];
            rsp_t stage_data  [STAGES];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < STAGES; i++) stage_valid[i] <= 1'b0;
                end else begin
                    stage_valid[0] <= accept;
                    for (int i = 1; i < STAGES; i++) stage_valid[i] <= stage_valid[i-1];
                end
            end

            always_ff @(posedge clock) begin
                stage_data[0] <= rd_entry;
                for (int i = 1; i < STAGES; i++) stage_data[i] <= stage_data[i-1];
            end

            assign push       = stage_valid[STAGES-1];
            assign push_entry = stage_data[STAGES-1];
        end
    endgenerate

    sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (MAX_OUT)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push && !fifo_full),
        .push_data (push_entry),
        .pop       (rsp_fire),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_instr = fifo_empty ? NOP_INSTR : head_entry.instr;
    assign rsp_err   = !fifo_empty && head_entry.err;

    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= '0;
        end else if (accept && !rsp_fire) begin
            outstanding <= outstanding + 1'b1;
        end else if (rsp_fire && !accept) begin
            outstanding <= outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a queue-of-responses model with ready times is checked every cycle,
// directed scenarios pin the model with literal values, then a randomized phase runs.
module tb_imem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int MAX_OUT = 4;
    localparam int IW      = $clog2(DEPTH);

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr  = '0;
    logic        rsp_ready = 1'b0;
    logic        load_en   = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_err;

    always #5 clock = ~clock;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: every accepted request becomes a pending response that may be shown from cycle 'at'.
    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          at;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } log_t;

    exp_t        model_q [$];
    logic [31:0] model_mem [DEPTH];
    int          acc_log [$];
    log_t        rsp_log [$];
    int          cyc   = 0;
    bit          armed = 1'b0;
    logic        exp_valid;
    logic        exp_ready;
    logic        bad;

    always @(negedge clock) begin
        exp_valid = (model_q.size() > 0) && (model_q[0].at <= cyc);
        exp_ready = (model_q.size() < MAX_OUT) && !load_en && !reset;
        if (armed) begin
            check("req_ready", req_ready, exp_ready);
            if (!reset) begin
                check("rsp_valid", rsp_valid, exp_valid);
                if (exp_valid) begin
                    check("rsp_instr", rsp_instr, model_q[0].instr);
                    check("rsp_err", rsp_err, model_q[0].err);
                end
            end
        end
        if (reset) begin
            model_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (exp_valid && rsp_ready) begin
                rsp_log.push_back('{rsp_instr, rsp_err, cyc});
                void'(model_q.pop_front());
            end
            if (req_valid && exp_ready) begin
                bad = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
                model_q.push_back('{bad ? 32'h0 : model_mem[req_addr[IW+1:2]], bad, cyc + LATENCY});
                acc_log.push_back(cyc);
            end
        end
        if (armed && load_en && (load_addr % 4 == 0) && (load_addr / 4 < DEPTH))
            model_mem[load_addr[IW+1:2]] = load_data;
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && model_q.size() > 0; i++) tick();
        check("drain_done", model_q.size(), 0);
        rsp_ready = 1'b0;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        rsp_log.delete();
    endtask

    logic [31:0] basic_words [4] = '{32'h8C01_0000, 32'h8C02_0004, 32'h0022_1820, 32'hAC03_0008};
    logic [31:0] err_words   [3] = '{32'h0, 32'h0, 32'h0050_0093};
    logic        err_flags   [3] = '{1'b1, 1'b1, 1'b0};
    int          r;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_req_ready", req_ready, 1);
        check("post_reset_rsp_instr", rsp_instr, 0);
        check("post_reset_rsp_err", rsp_err, 0);
        tick();

        for (int i = 0; i < DEPTH; i++) load_word(32'(i * 4), $urandom);
        for (int i = 0; i < 4; i++) load_word(32'(i * 4), basic_words[i]);
        load_word(32'h10, 32'h0050_0093);

        // Basic fetch: four back-to-back requests, first answer two cycles after accept.
        clear_logs();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * 4);
            tick();
        end
        req_valid = 1'b0;
        repeat (6) tick();
        check("basic_count", rsp_log.size(), 4);
        if (rsp_log.size() == 4 && acc_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("basic_instr", rsp_log[i].instr, basic_words[i]);
                check("basic_err", rsp_log[i].err, 0);
                check("basic_latency", rsp_log[i].cyc - acc_log[0], 2 + i);
            end
        end

        // Misaligned and out-of-range requests, then a good one.
        clear_logs();
        req_valid = 1'b1;
        req_addr = 32'h0000_0002; tick();
        req_addr = 32'h0000_0400; tick();
        req_addr = 32'h0000_0010; tick();
        req_valid = 1'b0;
        repeat (6) tick();
        check("err_count", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("err_instr", rsp_log[i].instr, err_words[i]);
                check("err_flag", rsp_log[i].err, err_flags[i]);
            end
        end

        // Backpressure: only MAX_OUT accepted, head holds, drain in order.
        clear_logs();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 32'((i % 4) * 4);
            tick();
        end
        @(negedge clock);
        check("bp_accepted", acc_log.size(), 4);
        check("bp_req_ready", req_ready, 0);
        check("bp_head", rsp_instr, 32'h8C01_0000);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        check("bp_ready_before_pop", req_ready, 0);
        tick();
        @(negedge clock);
        check("bp_ready_after_pop", req_ready, 1);
        tick();
        drain();
        check("bp_drained", rsp_log.size(), 4);
        if (rsp_log.size() == 4)
            for (int i = 0; i < 4; i++) check("bp_order", rsp_log[i].instr, basic_words[i]);

        // Request and response handshake in the same cycle while full.
        clear_logs();
        req_valid = 1'b1;
        req_addr  = 32'h0;
        repeat (6) tick();
        rsp_ready = 1'b1;
        @(negedge clock);
        check("full_pop_req_ready", req_ready, 0);
        check("full_pop_rsp_valid", rsp_valid, 1);
        tick();
        rsp_ready = 1'b0;
        @(negedge clock);
        check("full_next_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        @(negedge clock);
        check("full_again_req_ready", req_ready, 0);
        tick();
        check("full_accepts", acc_log.size(), 5);
        drain();

        // Preload between two fetches of the same word.
        clear_logs();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        load_en   = 1'b1;
        load_addr = 32'h8;
        load_data = 32'hDEAD_BEEF;
        @(negedge clock);
        check("load_req_ready", req_ready, 0);
        tick();
        load_en = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("load_accepts", acc_log.size(), 2);
        check("load_rsp_count", rsp_log.size(), 2);
        if (rsp_log.size() == 2) begin
            check("load_old_word", rsp_log[0].instr, 32'h0022_1820);
            check("load_new_word", rsp_log[1].instr, 32'hDEAD_BEEF);
        end

        // Reset with three fetches in flight.
        clear_logs();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(i * 4);
            tick();
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        tick();
        rsp_ready = 1'b1;
        repeat (6) tick();
        check("rst_no_stale", rsp_log.size(), 0);
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("rst_mem_kept_count", rsp_log.size(), 1);
        if (rsp_log.size() == 1) check("rst_mem_kept", rsp_log[0].instr, 32'h8C01_0000);

        // Randomized traffic with occasional bad addresses, preloads and resets.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 399) == 0);
            req_valid = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 15);
            if (r == 0)      req_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 1) req_addr = 32'(DEPTH * 4) + (32'($urandom_range(0, 4095)) << 2);
            else             req_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            rsp_ready = ($urandom_range(0, 9) < 6);
            load_en   = ($urandom_range(0, 29) == 0);
            load_addr = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom_range(0, DEPTH - 1)) << 2);
            load_data = $urandom;
            tick();
        end
        reset   = 1'b0;
        load_en = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
